// File: rtl/plic_tl_arbiter_if.sv
// Two-requester TileLink-UL A/D bundle seen by the PLIC front-end arbiter.
// Handshake: a beat transfers on a rising clock edge where valid && ready; once raised, valid and payload are held until that edge.
interface plic_tl_arbiter_if;
  logic [1:0]       in_a_valid;
  logic [1:0]       in_a_ready;
  logic [1:0][2:0]  in_a_opcode;
  logic [1:0][2:0]  in_a_param;
  logic [1:0][1:0]  in_a_size;
  logic [1:0][10:0] in_a_source;
  logic [1:0][27:0] in_a_address;
  logic [1:0][7:0]  in_a_mask;
  logic [1:0][63:0] in_a_data;
  logic [1:0]       in_a_corrupt;

  logic [1:0]       in_d_valid;
  logic [1:0]       in_d_ready;
  logic [1:0][2:0]  in_d_opcode;
  logic [1:0][1:0]  in_d_size;
  logic [1:0][10:0] in_d_source;
  logic [1:0][63:0] in_d_data;

  logic             out_a_valid;
  logic             out_a_ready;
  logic [2:0]       out_a_opcode;
  logic [2:0]       out_a_param;
  logic [1:0]       out_a_size;
  logic [10:0]      out_a_source;
  logic [27:0]      out_a_address;
  logic [7:0]       out_a_mask;
  logic [63:0]      out_a_data;
  logic             out_a_corrupt;

  logic             out_d_valid;
  logic             out_d_ready;
  logic [2:0]       out_d_opcode;
  logic [1:0]       out_d_size;
  logic [10:0]      out_d_source;
  logic [63:0]      out_d_data;

  modport slave (
    input  in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source,
           in_a_address, in_a_mask, in_a_data, in_a_corrupt,
    output in_a_ready,
    output in_d_valid, in_d_opcode, in_d_size, in_d_source, in_d_data,
    input  in_d_ready,
    output out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source,
           out_a_address, out_a_mask, out_a_data, out_a_corrupt,
    input  out_a_ready,
    input  out_d_valid, out_d_opcode, out_d_size, out_d_source, out_d_data,
    output out_d_ready
  );

  modport master (
    output in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source,
           in_a_address, in_a_mask, in_a_data, in_a_corrupt,
    input  in_a_ready,
    input  in_d_valid, in_d_opcode, in_d_size, in_d_source, in_d_data,
    output in_d_ready,
    input  out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source,
           out_a_address, out_a_mask, out_a_data, out_a_corrupt,
    output out_a_ready,
    output out_d_valid, out_d_opcode, out_d_size, out_d_source, out_d_data,
    input  out_d_ready
  );
endinterface

// File: rtl/plic_tl_arbiter.sv
// Round-robin 2:1 TileLink A-channel arbiter in front of the PLIC, with an
// in-order FIFO of grant ids that steers each D response back to its issuer.
module plic_tl_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  plic_tl_arbiter_if.slave         io_bus,
  output logic [$clog2(DEPTH):0]   o_outstanding,
  output logic                     o_err,
  output logic                     o_dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

  lock_state_t   r_state, w_state_nxt;
  logic          r_lock_id, w_lock_id_nxt;
  logic          r_rr;
  logic          r_fifo [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic w_full, w_empty, w_grant, w_a_valid, w_a_fire;
  logic w_head, w_d_fire, w_d_drop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // A stalled grant stays with its requester until it fires.
  always_comb begin
    w_grant = io_bus.in_a_valid[1];
    if (r_state == ST_LOCKED)
      w_grant = r_lock_id;
    else if (&io_bus.in_a_valid)
      w_grant = r_rr;
  end

  always_comb begin
    w_state_nxt   = ST_OPEN;
    w_lock_id_nxt = r_lock_id;
    if (w_a_valid && !io_bus.out_a_ready) begin
      w_state_nxt   = ST_LOCKED;
      w_lock_id_nxt = w_grant;
    end
  end

  assign w_a_valid = io_bus.in_a_valid[w_grant] && !w_full && !i_rst;
  assign w_a_fire  = w_a_valid && io_bus.out_a_ready;

  assign io_bus.out_a_valid   = w_a_valid;
  assign io_bus.in_a_ready    = {w_grant, ~w_grant} &
                                {2{io_bus.out_a_ready && !w_full && !i_rst}};
  assign io_bus.out_a_opcode  = io_bus.in_a_opcode[w_grant];
  assign io_bus.out_a_param   = io_bus.in_a_param[w_grant];
  assign io_bus.out_a_size    = io_bus.in_a_size[w_grant];
  assign io_bus.out_a_source  = io_bus.in_a_source[w_grant];
  assign io_bus.out_a_address = io_bus.in_a_address[w_grant];
  assign io_bus.out_a_mask    = io_bus.in_a_mask[w_grant];
  assign io_bus.out_a_data    = io_bus.in_a_data[w_grant];
  assign io_bus.out_a_corrupt = io_bus.in_a_corrupt[w_grant];

  // With nothing outstanding a D beat is swallowed and flagged as an error.
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_d_fire = io_bus.out_d_valid && io_bus.out_d_ready && !w_empty;
  assign w_d_drop = io_bus.out_d_valid && w_empty;

  assign io_bus.in_d_valid   = {w_head, ~w_head} &
                               {2{io_bus.out_d_valid && !w_empty && !i_rst}};
  assign io_bus.out_d_ready  = !i_rst && (w_empty || io_bus.in_d_ready[w_head]);
  assign io_bus.in_d_opcode  = {2{io_bus.out_d_opcode}};
  assign io_bus.in_d_size    = {2{io_bus.out_d_size}};
  assign io_bus.in_d_source  = {2{io_bus.out_d_source}};
  assign io_bus.in_d_data    = {2{io_bus.out_d_data}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_OPEN;
      r_lock_id <= 1'b0;
      r_rr      <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      if (w_a_fire) begin
        r_rr     <= ~w_grant;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_d_fire)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_a_fire) - CW'(w_d_fire);
      if (w_d_drop)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_a_fire)
      r_fifo[r_wr_ptr] <= w_grant;
  end

  assign o_outstanding = r_count;
  assign o_err         = r_err;
  assign o_dbg_state   = (r_state == ST_LOCKED);
endmodule
